char_buf_ctrl: RTL

CHAR_BUF_CTRL -- requirements
Module: char_buf_ctrl

---
 rtl/vga_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 18 +
 rtl/char_buf_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and defaults for the character-buffer write controller.
// Holds the controller FSM encoding and buffer geometry.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GRANT,
    WRITE,
    PAUSE
  } state_t;

  localparam int         CHAR_DEPTH_DEF = 256;
  localparam logic [7:0] BLANK_CODE_DEF = 8'h20;
  localparam logic [4:0] MAX_LEN        = 5'd16;

  // Strings never span more than one grid row.
  function automatic logic [4:0] sat_len(input logic [4:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Favoured requester first, the other one otherwise.
  always_comb begin
    gnt = 2'b00;
    if (req[ptr])
      gnt = ptr ? 2'b10 : 2'b01;
    else if (req[!ptr])
      gnt = ptr ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/char_buf_ctrl.sv
// Character-buffer write controller: blanking-window clear and
// round-robin string writes from two requesters.
module char_buf_ctrl
  import vga_pkg::*;
#(
  parameter int         CHAR_DEPTH = CHAR_DEPTH_DEF,
  parameter logic [7:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vblnk,
  input  logic            clr_req,
  input  logic [1:0]      req,
  input  logic [1:0][7:0] req_addr,
  input  logic [1:0][4:0] req_len,
  input  logic [1:0][7:0] req_data,
  output logic [1:0]      gnt,
  output logic [1:0]      pop,
  output logic [2:0]      done,
  output logic            wr_en,
  output logic [7:0]      wr_addr,
  output logic [7:0]      wr_data
);

  localparam int CW = $clog2(CHAR_DEPTH) + 1;
  localparam int IW = (CW > 5) ? CW : 5;
  localparam logic [IW-1:0] DEPTH_END = IW'(CHAR_DEPTH);

  state_t        state;
  logic          clr_mode;
  logic          owner;
  logic          ptr;
  logic [7:0]    base;
  logic [4:0]    len;
  logic [IW-1:0] idx;

  logic [1:0] arb_gnt;
  logic       own_req;
  logic [7:0] own_data;
  logic [7:0] xfer_addr;
  logic       last;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Current transfer view: owner's inputs and end-of-operation flag.
  always_comb begin
    own_req   = req[owner];
    own_data  = req_data[owner];
    xfer_addr = base + 8'(idx);
    last      = clr_mode ? (idx == DEPTH_END)
                         : (idx == IW'(len));
  end

  // Controller FSM; every output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clr_mode <= 1'b0;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      base     <= '0;
      len      <= '0;
      idx      <= '0;
      gnt      <= '0;
      pop      <= '0;
      done     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      pop   <= '0;
      done  <= '0;
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (clr_req) begin
            state    <= CLEAR;
            clr_mode <= 1'b1;
          end else if (|req) begin
            state    <= GRANT;
            clr_mode <= 1'b0;
            gnt      <= arb_gnt;
            owner    <= arb_gnt[1];
            ptr      <= ~arb_gnt[1];
            base     <= req_addr[arb_gnt[1]];
            len      <= sat_len(req_len[arb_gnt[1]]);
          end
        end
        GRANT: begin
          if (!own_req) begin
            state <= IDLE;
            gnt   <= '0;
          end else if (len == 5'd0) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= owner ? 3'b010 : 3'b001;
          end else begin
            state <= WRITE;
          end
        end
        CLEAR, WRITE, PAUSE: begin
          if (!clr_mode && !own_req) begin
            state <= IDLE;
            gnt   <= '0;
          end else if (last) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= clr_mode ? 3'b100 :
                     owner    ? 3'b010 : 3'b001;
          end else if (vblnk) begin
            state <= clr_mode ? CLEAR : WRITE;
            idx   <= idx + 1'b1;
            wr_en <= 1'b1;
            if (clr_mode) begin
              wr_addr <= 8'(idx);
              wr_data <= BLANK_CODE;
            end else begin
              wr_addr <= xfer_addr;
              wr_data <= own_data;
              pop     <= owner ? 2'b10 : 2'b01;
            end
          end else begin
            state <= PAUSE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
